// File: rtl/dma_copy_engine_pkg.sv
// dma_copy_engine shared types.
// FSM state encoding and the burst command bundle.
package dma_copy_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    WR_CMD,
    XFER,
    WAIT_BACK,
    DONE
  } state_t;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] length;
  } cmd_t;

  function automatic logic [31:0] min32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine bus bundle: job, commands,
// data beats, write acknowledge and done.
interface dma_copy_engine_if #(
  parameter int WIDTH = 512
);
  logic             job_valid;
  logic             job_ready;
  logic [63:0]      job_src;
  logic [63:0]      job_dst;
  logic [31:0]      job_len;

  logic             read_cmd_valid;
  logic             read_cmd_ready;
  logic [63:0]      read_cmd_address;
  logic [31:0]      read_cmd_length;

  logic             write_cmd_valid;
  logic             write_cmd_ready;
  logic [63:0]      write_cmd_address;
  logic [31:0]      write_cmd_length;

  logic             read_data_valid;
  logic             read_data_ready;
  logic [WIDTH-1:0] read_data_data;

  logic               write_data_valid;
  logic               write_data_ready;
  logic [WIDTH-1:0]   write_data_data;
  logic [WIDTH/8-1:0] write_data_keep;
  logic               write_data_last;

  logic             back_valid;
  logic             back_ready;
  logic             done;

  modport master (
    input  job_valid, job_src, job_dst, job_len,
    output job_ready,
    output read_cmd_valid, read_cmd_address,
    output read_cmd_length,
    input  read_cmd_ready,
    output write_cmd_valid, write_cmd_address,
    output write_cmd_length,
    input  write_cmd_ready,
    input  read_data_valid, read_data_data,
    output read_data_ready,
    output write_data_valid, write_data_data,
    output write_data_keep, write_data_last,
    input  write_data_ready,
    input  back_valid,
    output back_ready,
    output done
  );

  modport slave (
    output job_valid, job_src, job_dst, job_len,
    input  job_ready,
    input  read_cmd_valid, read_cmd_address,
    input  read_cmd_length,
    output read_cmd_ready,
    input  write_cmd_valid, write_cmd_address,
    input  write_cmd_length,
    output write_cmd_ready,
    output read_data_valid, read_data_data,
    input  read_data_ready,
    input  write_data_valid, write_data_data,
    input  write_data_keep, write_data_last,
    output write_data_ready,
    output back_valid,
    input  back_ready,
    input  done
  );

endinterface

// File: rtl/dma_copy_engine_beat_fifo.sv
// beat_fifo: synchronous FIFO between read and write data.
// A pop frees the slot a same-cycle push needs when full.
module beat_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rp];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: splits a copy job into bursts of
// read/write command pairs and streams beats through a FIFO.
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int MAX_BURST  = 4096,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clock,
  input  logic              reset,
  dma_copy_engine_if.master bus
);

  localparam int BB   = WIDTH / 8;
  localparam int LB   = $clog2(BB);
  localparam int BMAX = MAX_BURST / BB;
  localparam int CW   = $clog2(BMAX + 1);

  state_t        state;
  cmd_t          rd_cmd;
  cmd_t          wr_cmd;
  logic [31:0]   remaining;
  logic [CW-1:0] beats;
  logic [CW-1:0] rcvd;
  logic [CW-1:0] sent;
  logic          done_q;

  logic [31:0]   len_m;
  logic [31:0]   rem_next;
  logic [31:0]   nb_src;
  logic [31:0]   nb;
  logic [CW-1:0] nbeats;
  logic          full;
  logic          empty;
  logic          rd_fire;
  logic          wr_fire;

  always_comb begin
    len_m    = bus.job_len & ~32'(BB - 1);
    rem_next = remaining - rd_cmd.length;
    nb_src   = (state == IDLE) ? len_m : rem_next;
    nb       = min32(nb_src, 32'(MAX_BURST));
    nbeats   = CW'(nb >> LB);
  end

  assign bus.job_ready         = (state == IDLE);
  assign bus.read_cmd_valid    = (state == RD_CMD);
  assign bus.read_cmd_address  = rd_cmd.address;
  assign bus.read_cmd_length   = rd_cmd.length;
  assign bus.write_cmd_valid   = (state == WR_CMD);
  assign bus.write_cmd_address = wr_cmd.address;
  assign bus.write_cmd_length  = wr_cmd.length;
  assign bus.back_ready        = (state == WAIT_BACK);
  assign bus.done              = done_q;

  assign bus.read_data_ready =
    (state == XFER) && !full && (rcvd < beats);
  assign bus.write_data_valid =
    (state == XFER) && !empty && (sent < beats);
  assign bus.write_data_keep = '1;
  assign bus.write_data_last = (sent == beats - CW'(1));

  assign rd_fire = bus.read_data_valid && bus.read_data_ready;
  assign wr_fire = bus.write_data_valid && bus.write_data_ready;

  beat_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_fire),
    .push_data (bus.read_data_data),
    .pop       (wr_fire),
    .pop_data  (bus.write_data_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      rd_cmd    <= '0;
      wr_cmd    <= '0;
      remaining <= '0;
      beats     <= '0;
      rcvd      <= '0;
      sent      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.job_valid) begin
          rd_cmd    <= '{bus.job_src, nb};
          wr_cmd    <= '{bus.job_dst, nb};
          remaining <= len_m;
          beats     <= nbeats;
          state     <= (len_m != '0) ? RD_CMD : DONE;
        end
        RD_CMD: if (bus.read_cmd_ready) state <= WR_CMD;
        WR_CMD: if (bus.write_cmd_ready) begin
          rcvd  <= '0;
          sent  <= '0;
          state <= XFER;
        end
        XFER: begin
          if (rd_fire) rcvd <= rcvd + CW'(1);
          if (wr_fire) begin
            sent <= sent + CW'(1);
            if (sent == beats - CW'(1)) state <= WAIT_BACK;
          end
        end
        // addresses wrap modulo 2^64 by plain overflow
        WAIT_BACK: if (bus.back_valid) begin
          rd_cmd    <= '{rd_cmd.address + 64'(rd_cmd.length), nb};
          wr_cmd    <= '{wr_cmd.address + 64'(rd_cmd.length), nb};
          remaining <= rem_next;
          beats     <= nbeats;
          state     <= (rem_next != '0) ? RD_CMD : DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Randomised bench for dma_copy_engine with memory responders
// and a burst-splitting reference model.
module tb_dma_copy_engine;

  localparam int W  = 512;
  localparam int FD = 4;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] l;
  } tcmd_t;

  typedef struct packed {
    logic [W-1:0]   d;
    logic [W/8-1:0] k;
    logic           l;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  dma_copy_engine_if #(.WIDTH(W)) bus ();

  dma_copy_engine #(
    .WIDTH      (W),
    .MAX_BURST  (4096),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  tcmd_t       obs_rd[$], obs_wr[$], exp_rd[$], exp_wr[$];
  beat_t       obs_b[$], exp_b[$];
  logic [63:0] rd_pend[$];
  logic [63:0] seed;

  int owed, backs, done_cnt, done_cyc, viol;
  int occ, max_occ, rcmd_first, rfire_first, wv_first;
  bit bp_mode     = 1'b0;
  bit back_always = 1'b0;

  always @(posedge clock) cyc++;

  function automatic logic [W-1:0] beat_of(input logic [63:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < W / 64; i++)
      r[i*64 +: 64] = (a ^ seed) * 64'(2 * i + 1) + 64'(i);
    return r;
  endfunction

  // Reference: split into <=4096-byte bursts, beats read in order
  task automatic model_job(input logic [63:0] src,
                           input logic [63:0] dst,
                           input logic [31:0] len);
    logic [31:0] lm, off, b;
    tcmd_t c;
    beat_t e;
    lm  = len & ~32'd63;
    off = 0;
    while (off < lm) begin
      b = (lm - off > 32'd4096) ? 32'd4096 : lm - off;
      c.a = src + 64'(off); c.l = b; exp_rd.push_back(c);
      c.a = dst + 64'(off); c.l = b; exp_wr.push_back(c);
      for (int i = 0; i < int'(b / 64); i++) begin
        e.d = beat_of(src + 64'(off) + 64'(64 * i));
        e.k = '1;
        e.l = (i == int'(b / 64) - 1);
        exp_b.push_back(e);
      end
      off += b;
    end
  endtask

  function automatic int sb_diffs();
    int n = 0;
    if (obs_rd.size() != exp_rd.size()) n++;
    else foreach (exp_rd[i]) if (obs_rd[i] !== exp_rd[i]) n++;
    if (obs_wr.size() != exp_wr.size()) n++;
    else foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) n++;
    if (obs_b.size() != exp_b.size()) n++;
    else foreach (exp_b[i]) if (obs_b[i] !== exp_b[i]) n++;
    return n;
  endfunction

  // Responders: all slave-side inputs except job/reset
  initial begin : responder
    bit    rc_hold, wc_hold;
    tcmd_t rc_prev, wc_prev, cur;
    beat_t bt;
    rc_hold = 0; wc_hold = 0;
    rc_prev = '0; wc_prev = '0;
    bus.read_cmd_ready   = 0;
    bus.write_cmd_ready  = 0;
    bus.read_data_valid  = 0;
    bus.read_data_data   = '0;
    bus.write_data_ready = 0;
    bus.back_valid       = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rd_pend.delete();
        owed = 0; occ = 0;
        rc_hold = 0; wc_hold = 0;
        bus.read_cmd_ready   = 0;
        bus.write_cmd_ready  = 0;
        bus.read_data_valid  = 0;
        bus.write_data_ready = 0;
        bus.back_valid       = 0;
      end else begin
        if (bus.read_cmd_valid && rcmd_first < 0) rcmd_first = cyc;
        if (bus.write_data_valid && wv_first < 0) wv_first = cyc;
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.back_ready && owed <= 0) viol++;

        cur = '{bus.read_cmd_address, bus.read_cmd_length};
        if (rc_hold && !(bus.read_cmd_valid && cur == rc_prev)) viol++;
        bus.read_cmd_ready = 1'($urandom_range(0, 1));
        if (bus.read_cmd_valid && bus.read_cmd_ready) begin
          obs_rd.push_back(cur);
          for (int i = 0; i < int'(cur.l / 64); i++)
            rd_pend.push_back(cur.a + 64'(64 * i));
        end
        rc_hold = bus.read_cmd_valid && !bus.read_cmd_ready;
        rc_prev = cur;

        cur = '{bus.write_cmd_address, bus.write_cmd_length};
        if (wc_hold && !(bus.write_cmd_valid && cur == wc_prev)) viol++;
        bus.write_cmd_ready = 1'($urandom_range(0, 1));
        if (bus.write_cmd_valid && bus.write_cmd_ready)
          obs_wr.push_back(cur);
        wc_hold = bus.write_cmd_valid && !bus.write_cmd_ready;
        wc_prev = cur;

        if (rd_pend.size() > 0 &&
            (bp_mode || $urandom_range(0, 3) != 0)) begin
          bus.read_data_valid = 1;
          bus.read_data_data  = beat_of(rd_pend[0]);
        end else begin
          bus.read_data_valid = 0;
        end
        if (bus.read_data_valid && bus.read_data_ready) begin
          void'(rd_pend.pop_front());
          occ++;
          if (rfire_first < 0) rfire_first = cyc;
        end

        bus.write_data_ready = bp_mode ? cyc[0]
                               : ($urandom_range(0, 3) != 0);
        if (bus.write_data_valid && bus.write_data_ready) begin
          bt.d = bus.write_data_data;
          bt.k = bus.write_data_keep;
          bt.l = bus.write_data_last;
          obs_b.push_back(bt);
          occ--;
          if (bt.l) owed++;
        end
        if (occ > max_occ) max_occ = occ;

        bus.back_valid = back_always ||
                         (owed > 0 && $urandom_range(0, 1) == 1);
        if (bus.back_valid && bus.back_ready) begin
          backs++;
          owed--;
        end
      end
    end
  end

  task automatic start_job(input logic [63:0] src,
                           input logic [63:0] dst,
                           input logic [31:0] len,
                           output int fcyc, output bit ok);
    int t;
    @(posedge clock);
    obs_rd.delete(); obs_wr.delete(); obs_b.delete();
    exp_rd.delete(); exp_wr.delete(); exp_b.delete();
    backs = 0; done_cnt = 0; done_cyc = -1; viol = 0;
    max_occ = 0; rcmd_first = -1; rfire_first = -1;
    wv_first = -1;
    model_job(src, dst, len);
    @(negedge clock);
    bus.job_src   = src;
    bus.job_dst   = dst;
    bus.job_len   = len;
    bus.job_valid = 1;
    t = 0;
    while (!bus.job_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    ok   = bus.job_ready;
    fcyc = cyc;
    @(negedge clock);
    bus.job_valid = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clock);
      if (done_cnt > 0) begin ok = 1; break; end
    end
    repeat (6) @(negedge clock);
  endtask

  function automatic logic [6:0] ctl_vec();
    return {bus.job_ready, bus.read_cmd_valid,
            bus.write_cmd_valid, bus.read_data_ready,
            bus.write_data_valid, bus.back_ready, bus.done};
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_assert++;
    if (ctl_vec() !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_in: ctl=%b required 1000000", ctl_vec());
    end
    @(posedge clock); #1 reset = 1;
    repeat (2) @(negedge clock);
    n_assert++;
    if (ctl_vec() !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_out: ctl=%b required 1000000", ctl_vec());
    end
  endtask

  task automatic test_single();
    int f; bit ok; int d;
    start_job(64'h0, 64'h10000, 256, f, ok);
    wait_done(ok);
    n_assert++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL single_done: seen=%0b required 1", ok);
    end
    n_assert++;
    if (rcmd_first - f !== 1) begin
      n_fail++;
      $display("FAIL single_cmd_lat: %0d required 1", rcmd_first - f);
    end
    n_assert++;
    if (wv_first - rfire_first !== 1) begin
      n_fail++;
      $display("FAIL single_beat_lat: %0d required 1",
               wv_first - rfire_first);
    end
    d = sb_diffs();
    n_assert++;
    if (d !== 0) begin
      n_fail++;
      $display("FAIL single_sb: diffs=%0d beats=%0d/%0d required 0",
               d, obs_b.size(), exp_b.size());
    end
    n_assert++;
    if (done_cnt !== 1 || backs !== 1) begin
      n_fail++;
      $display("FAIL single_counts: done=%0d backs=%0d required 1/1",
               done_cnt, backs);
    end
  endtask

  task automatic test_multi();
    int f; bit ok; int d;
    start_job(64'h0, 64'h40000, 10240, f, ok);
    wait_done(ok);
    d = sb_diffs();
    n_assert++;
    if (ok !== 1'b1 || d !== 0) begin
      n_fail++;
      $display("FAIL multi_sb: done=%0b diffs=%0d required 1/0", ok, d);
    end
    n_assert++;
    if (obs_rd.size() !== 3) begin
      n_fail++;
      $display("FAIL multi_bursts: %0d required 3", obs_rd.size());
    end
    n_assert++;
    if (done_cnt !== 1 || backs !== 3 || viol !== 0) begin
      n_fail++;
      $display("FAIL multi_counts: done=%0d backs=%0d viol=%0d required 1/3/0",
               done_cnt, backs, viol);
    end
  endtask

  task automatic test_zero();
    int f; bit ok;
    start_job({$urandom, $urandom}, 64'h77000, 0, f, ok);
    wait_done(ok);
    n_assert++;
    if (done_cyc - f !== 2) begin
      n_fail++;
      $display("FAIL zero_done_lat: %0d required 2", done_cyc - f);
    end
    n_assert++;
    if (obs_rd.size() + obs_wr.size() !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL zero_cmds: cmds=%0d done=%0d required 0/1",
               obs_rd.size() + obs_wr.size(), done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int f; bit ok; int d;
    bp_mode = 1;
    start_job(64'h20000, 64'h90000, 4096, f, ok);
    wait_done(ok);
    bp_mode = 0;
    d = sb_diffs();
    n_assert++;
    if (ok !== 1'b1 || d !== 0) begin
      n_fail++;
      $display("FAIL bp_sb: done=%0b diffs=%0d beats=%0d required 1/0/64",
               ok, d, obs_b.size());
    end
    n_assert++;
    if (max_occ !== FD) begin
      n_fail++;
      $display("FAIL bp_fill: max occupancy=%0d required %0d", max_occ, FD);
    end
  endtask

  task automatic test_back_early();
    int f; bit ok; int d;
    back_always = 1;
    start_job(64'h3000, 64'h83000, 10240, f, ok);
    wait_done(ok);
    back_always = 0;
    d = sb_diffs();
    n_assert++;
    if (backs !== 3 || viol !== 0) begin
      n_fail++;
      $display("FAIL back_early: backs=%0d viol=%0d required 3/0",
               backs, viol);
    end
    n_assert++;
    if (ok !== 1'b1 || d !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL back_early_sb: done=%0d diffs=%0d required 1/0",
               done_cnt, d);
    end
  endtask

  task automatic test_reset_mid();
    int f; bit ok; int d; int nb, nr, nw;
    start_job(64'h100000, 64'h200000, 4096, f, ok);
    for (int t = 0; t < 5000 && obs_b.size() < 30; t++)
      @(negedge clock);
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    @(negedge clock);
    n_assert++;
    if (ctl_vec() !== 7'b1000000) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: ctl=%b required 1000000", ctl_vec());
    end
    nb = obs_b.size(); nr = obs_rd.size(); nw = obs_wr.size();
    @(posedge clock); #1 reset = 1;
    repeat (20) @(negedge clock);
    n_assert++;
    if (obs_b.size() !== nb || obs_rd.size() !== nr ||
        obs_wr.size() !== nw || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: beats %0d->%0d done=%0d required no change/0",
               nb, obs_b.size(), done_cnt);
    end
    start_job(64'h5000, 64'h9000, 256, f, ok);
    wait_done(ok);
    d = sb_diffs();
    n_assert++;
    if (ok !== 1'b1 || d !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL rst_mid_after: done=%0d diffs=%0d required 1/0",
               done_cnt, d);
    end
  endtask

  task automatic test_random();
    int f; bit ok; int d;
    logic [63:0] s;
    for (int j = 0; j < 4; j++) begin
      s = (j == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : {$urandom, $urandom};
      start_job(s, {$urandom, $urandom},
                32'($urandom_range(0, 9000)), f, ok);
      wait_done(ok);
      d = sb_diffs();
      n_assert++;
      if (ok !== 1'b1 || d !== 0 || done_cnt !== 1 || viol !== 0) begin
        n_fail++;
        $display("FAIL random_job%0d: done=%0d diffs=%0d viol=%0d required 1/0/0",
                 j, done_cnt, d, viol);
      end
    end
  endtask

  initial begin
    seed          = {$urandom, $urandom};
    bus.job_valid = 0;
    bus.job_src   = '0;
    bus.job_dst   = '0;
    bus.job_len   = '0;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_backpressure();
    test_back_early();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
